// File: rtl/alu_sequencer.sv
// alu_sequencer: decodes ADDI/ADD/BNE, drives the datapath for one execute cycle, owns the PC.
// Three-state handshake sequencer: IDLE accepts, EXEC drives the datapath, RETIRE pulses retire.
module alu_sequencer #(
   parameter int REG_FILE_ADDR_WIDTH = 5,
   parameter int DATA_WIDTH = 32,
   parameter int PC_WIDTH = 32,
   parameter logic [PC_WIDTH-1:0] PC_RESET = '0
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           instr_valid,
   input  logic [DATA_WIDTH-1:0]          instr,
   output logic                           instr_ready,
   input  logic                           EQ,
   output logic [REG_FILE_ADDR_WIDTH-1:0] AD1,
   output logic [REG_FILE_ADDR_WIDTH-1:0] AD2,
   output logic [REG_FILE_ADDR_WIDTH-1:0] AD3,
   output logic                           WE3,
   output logic                           ALUsrc,
   output logic                           ALUctrl,
   output logic [DATA_WIDTH-1:0]          ImmOp,
   output logic [PC_WIDTH-1:0]            pc,
   output logic                           retire,
   output logic                           illegal
);
   typedef enum logic [1:0] {IDLE, EXEC, RETIRE} state_t;
   state_t r_state;
   logic r_bne, r_ill;
   logic w_addi, w_add, w_bne;
   logic [REG_FILE_ADDR_WIDTH-1:0] w_ad1, w_ad2, w_ad3;
   logic [DATA_WIDTH-1:0] w_imm;
   logic w_we;
   assign w_addi = instr[6:0] == 7'b0010011 && instr[14:12] == 3'b000;
   assign w_add  = instr[6:0] == 7'b0110011 && instr[14:12] == 3'b000 && instr[31:25] == 7'b0000000;
   assign w_bne  = instr[6:0] == 7'b1100011 && instr[14:12] == 3'b001;
   assign w_ad1  = (w_addi || w_add || w_bne) ? instr[19:15] : '0;
   assign w_ad2  = (w_add || w_bne) ? instr[24:20] : '0;
   assign w_ad3  = (w_addi || w_add) ? instr[11:7] : '0;
   // rd = x0 is hardwired zero, so its write enable is simply never raised
   assign w_we   = (w_addi || w_add) && instr[11:7] != 5'd0;
   assign w_imm  = w_addi ? {{(DATA_WIDTH-12){instr[31]}}, instr[31:20]} :
                   w_bne  ? {{(DATA_WIDTH-13){instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0} : '0;
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= IDLE;
         instr_ready <= 1'b1;
         pc          <= PC_RESET;
         AD1         <= '0;
         AD2         <= '0;
         AD3         <= '0;
         ImmOp       <= '0;
         WE3         <= 1'b0;
         ALUsrc      <= 1'b0;
         ALUctrl     <= 1'b0;
         retire      <= 1'b0;
         illegal     <= 1'b0;
         r_bne       <= 1'b0;
         r_ill       <= 1'b0;
      end else begin
         case (r_state)
            IDLE: if (instr_valid) begin
               r_state     <= EXEC;
               instr_ready <= 1'b0;
               AD1         <= w_ad1;
               AD2         <= w_ad2;
               AD3         <= w_ad3;
               ImmOp       <= w_imm;
               WE3         <= w_we;
               ALUsrc      <= w_addi;
               ALUctrl     <= w_bne;
               r_bne       <= w_bne;
               r_ill       <= !(w_addi || w_add || w_bne);
            end
            EXEC: begin
               r_state <= RETIRE;
               WE3     <= 1'b0;
               retire  <= 1'b1;
               illegal <= r_ill;
               pc      <= (r_bne && !EQ) ? pc + PC_WIDTH'($signed(ImmOp)) : pc + PC_WIDTH'(4);
            end
            RETIRE: begin
               r_state     <= IDLE;
               retire      <= 1'b0;
               illegal     <= 1'b0;
               instr_ready <= 1'b1;
            end
            default: r_state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer: scoreboard bench; a driver queues expected EXEC/RETIRE behaviour, a monitor checks it.
module tb_alu_sequencer;
   logic clk = 1'b0, rst = 1'b1, instr_valid = 1'b0, EQ = 1'b0;
   logic [31:0] instr = '0;
   logic instr_ready, WE3, ALUsrc, ALUctrl, retire, illegal;
   logic [4:0] AD1, AD2, AD3;
   logic [31:0] ImmOp, pc;
   typedef struct packed {
      logic [4:0] ad1, ad2, ad3;
      logic we, src, ctrl, chk2;
      logic [31:0] imm;
   } exec_t;
   typedef struct packed {
      logic [31:0] pc;
      logic ill;
   } ret_t;
   exec_t q_exec[$];
   ret_t q_ret[$];
   exec_t me;
   ret_t mr;
   int checks = 0, errors = 0, cyc = 0;
   logic [31:0] pc_m = '0;
   bit hs, hs2;
   alu_sequencer dut (
      .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr(instr), .instr_ready(instr_ready),
      .EQ(EQ), .AD1(AD1), .AD2(AD2), .AD3(AD3), .WE3(WE3), .ALUsrc(ALUsrc), .ALUctrl(ALUctrl),
      .ImmOp(ImmOp), .pc(pc), .retire(retire), .illegal(illegal)
   );
   always #5 clk = ~clk;
   always @(posedge clk) cyc++;
   // hs marks the EXEC cycle that follows an accepted handshake, hs2 the RETIRE cycle after it
   always @(posedge clk or posedge rst)
      if (rst) begin
         hs <= 1'b0;
         hs2 <= 1'b0;
      end else begin
         hs <= instr_valid && instr_ready;
         hs2 <= hs;
      end
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask
   always @(negedge clk) if (!rst) begin
      chk("instr_ready", instr_ready, !(hs || hs2));
      chk("retire", retire, hs2);
      if (!hs) chk("we_outside_exec", WE3, 0);
      if (hs) begin
         if (q_exec.size() == 0) begin
            checks++; errors++;
            $display("FAIL exec_queue: got unexpected EXEC cycle, expected none");
         end else begin
            me = q_exec.pop_front();
            chk("AD1", AD1, me.ad1);
            if (me.chk2) chk("AD2", AD2, me.ad2);
            chk("AD3", AD3, me.ad3);
            chk("WE3", WE3, me.we);
            chk("ALUsrc", ALUsrc, me.src);
            chk("ALUctrl", ALUctrl, me.ctrl);
            chk("ImmOp", ImmOp, me.imm);
         end
      end
      if (hs2) begin
         if (q_ret.size() == 0) begin
            checks++; errors++;
            $display("FAIL retire_queue: got unexpected retire, expected none");
         end else begin
            mr = q_ret.pop_front();
            chk("pc", pc, mr.pc);
            chk("illegal", illegal, mr.ill);
         end
      end else chk("illegal_idle", illegal, 0);
   end
   // reference model: classify the word by its RV32I fields and push what EXEC and RETIRE must show
   task automatic model(input logic [31:0] ins, input logic eq);
      exec_t e;
      ret_t r;
      logic [12:0] b;
      logic [31:0] step;
      e = '0;
      r = '0;
      step = 32'd4;
      if (ins[6:0] == 7'h13 && ins[14:12] == 3'd0) begin
         e.ad1 = ins[19:15];
         e.ad3 = ins[11:7];
         e.src = 1'b1;
         e.imm = int'($signed(ins[31:20]));
         e.we = ins[11:7] != 0;
      end else if (ins[6:0] == 7'h33 && ins[14:12] == 3'd0 && ins[31:25] == 7'd0) begin
         e.ad1 = ins[19:15];
         e.ad2 = ins[24:20];
         e.ad3 = ins[11:7];
         e.chk2 = 1'b1;
         e.we = ins[11:7] != 0;
      end else if (ins[6:0] == 7'h63 && ins[14:12] == 3'd1) begin
         e.ad1 = ins[19:15];
         e.ad2 = ins[24:20];
         e.chk2 = 1'b1;
         e.ctrl = 1'b1;
         b = {ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
         e.imm = int'($signed(b));
         if (!eq) step = e.imm;
      end else begin
         e.chk2 = 1'b1;
         r.ill = 1'b1;
      end
      pc_m = pc_m + step;
      r.pc = pc_m;
      q_exec.push_back(e);
      q_ret.push_back(r);
   endtask
   // called away from edges; returns #1 after the accepting edge, i.e. inside EXEC
   task automatic issue(input logic [31:0] ins, input logic eq, input bit keep, output int acc);
      int n;
      model(ins, eq);
      instr = ins;
      instr_valid = 1'b1;
      n = 0;
      while (!instr_ready && n < 20) begin
         @(posedge clk);
         #1;
         n++;
      end
      if (!instr_ready) begin
         checks++; errors++;
         $display("FAIL accept_timeout: got instr_ready=0 after 20 cycles, expected 1");
      end
      @(posedge clk);
      #1;
      acc = cyc;
      EQ = eq;
      if (!keep) instr_valid = 1'b0;
   endtask
   function automatic logic [31:0] rand_instr();
      logic [4:0] rd, rs1, rs2;
      rd = 5'($urandom);
      rs1 = 5'($urandom);
      rs2 = 5'($urandom);
      case ($urandom_range(0, 3))
         0: return {12'($urandom), rs1, 3'b000, rd, 7'h13};
         1: return {7'h00, rs2, rs1, 3'b000, rd, 7'h33};
         2: return {7'($urandom), rs2, rs1, 3'b001, 5'($urandom), 7'h63};
         default: return $urandom;
      endcase
   endfunction
   initial begin
      int a0, a1, a2;
      logic [31:0] ri;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_pc", pc, 0);
      chk("rst_ready", instr_ready, 1);
      chk("rst_we", WE3, 0);
      chk("rst_retire", retire, 0);
      chk("rst_illegal", illegal, 0);
      chk("rst_ad", {AD1, AD2, AD3}, 0);
      chk("rst_imm", ImmOp, 0);
      rst = 1'b0;
      issue(32'h00500513, 1'b0, 1'b0, a0);
      issue(32'h002081B3, 1'b0, 1'b0, a0);
      issue(32'hFE659CE3, 1'b0, 1'b0, a0);
      issue(32'h002081B3, 1'b1, 1'b0, a0);
      issue(32'h00500513, 1'b0, 1'b0, a0);
      issue(32'hFE659CE3, 1'b1, 1'b0, a0);
      issue(32'h00208033, 1'b0, 1'b0, a0);
      issue(32'hFFFFFFFF, 1'b0, 1'b0, a0);
      issue(32'h00100093, 1'b1, 1'b1, a0);
      issue(32'h00208133, 1'b0, 1'b1, a1);
      issue(32'h00311463, 1'b0, 1'b1, a2);
      instr_valid = 1'b0;
      chk("b2b_gap1", a1 - a0, 3);
      chk("b2b_gap2", a2 - a1, 3);
      for (int i = 0; i < 60; i++) begin
         repeat ($urandom_range(0, 2)) @(posedge clk);
         #1;
         ri = rand_instr();
         issue(ri, 1'($urandom), 1'($urandom_range(0, 1)), a0);
      end
      issue(32'h00500513, 1'b0, 1'b0, a0);
      @(negedge clk);
      #1;
      rst = 1'b1;
      #1;
      chk("async_pc", pc, 0);
      chk("async_ready", instr_ready, 1);
      chk("async_we", WE3, 0);
      chk("async_retire", retire, 0);
      q_ret.delete();
      pc_m = '0;
      @(posedge clk);
      #1;
      rst = 1'b0;
      chk("post_rst_pc", pc, 0);
      issue(32'h00500513, 1'b0, 1'b0, a0);
      repeat (5) @(negedge clk);
      chk("queues_drained", q_exec.size() + q_ret.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/alu_sequencer.md
Name: alu_sequencer

Overview:
- Control sequencer for the register-file/ALU datapath.
- Accepts one 32-bit RV32I instruction at a time over a valid/ready handshake and decodes it. Supported: ADDI, ADD, BNE; everything else is flagged illegal.
- Drives the datapath control and address inputs for exactly one execute cycle, then resolves the next PC using the datapath's EQ flag.
- Sits between the instruction source (fetch/test harness) and the datapath top; it owns the PC register.

Parameters:
- REG_FILE_ADDR_WIDTH, 5, register-file address width.
- DATA_WIDTH, 32, datapath and instruction width.
- PC_WIDTH, 32, program counter width.
- PC_RESET, 0, PC value after reset.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- instr_valid  input  1  instruction on instr is valid.
- instr  input  DATA_WIDTH  RV32I instruction word.
- instr_ready  output  1  sequencer can accept an instruction.
- EQ  input  1  datapath equality flag (RD1 == ALUop2).
- AD1  output  REG_FILE_ADDR_WIDTH  rs1 address.
- AD2  output  REG_FILE_ADDR_WIDTH  rs2 address.
- AD3  output  REG_FILE_ADDR_WIDTH  rd address.
- WE3  output  1  register-file write enable.
- ALUsrc  output  1  0 = RD2, 1 = ImmOp as ALU operand 2.
- ALUctrl  output  1  0 = add, 1 = compare.
- ImmOp  output  DATA_WIDTH  sign-extended immediate.
- pc  output  PC_WIDTH  current program counter.
- retire  output  1  one-cycle pulse: instruction completed.
- illegal  output  1  one-cycle pulse, coincident with retire: completed instruction was unsupported.

Behaviour:
- Reset (async, rst=1): state=IDLE; instr_ready=1.
  - pc=PC_RESET.
  - AD1/AD2/AD3/ImmOp=0; WE3/ALUsrc/ALUctrl/retire/illegal=0.
  - Reset asserted mid-EXEC aborts the instruction: no write, pc unchanged from PC_RESET.
- FSM states: IDLE, EXEC, RETIRE.
  - IDLE: instr_ready=1. On instr_valid=1, capture instr into a holding register and go to EXEC. Otherwise stay in IDLE.
  - EXEC: instr_ready=0.
    - Datapath outputs are driven from the decoded holding register and are stable for the whole cycle.
    - At the closing edge, update pc and go to RETIRE.
  - RETIRE: instr_ready=0; retire=1 for this single cycle; illegal=1 if the instruction was unsupported. Next state is always IDLE.
- Throughput: one instruction per 3 cycles. instr_valid is ignored outside IDLE.
- Decode (opcode[6:0], funct3[14:12], funct7[31:25]):
  - ADDI: opcode 0010011, funct3 000.
    - AD1=rs1[19:15], AD3=rd[11:7].
    - ALUsrc=1, ALUctrl=0.
    - ImmOp = sign-extend instr[31:20].
    - WE3=1 during EXEC only.
  - ADD: opcode 0110011, funct3 000, funct7 0000000.
    - AD1=rs1, AD2=rs2[24:20], AD3=rd.
    - ALUsrc=0, ALUctrl=0, ImmOp=0.
    - WE3=1 during EXEC only.
  - BNE: opcode 1100011, funct3 001.
    - AD1=rs1, AD2=rs2, AD3=0.
    - ALUsrc=0, ALUctrl=1, WE3=0.
    - ImmOp = sign-extend {instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}.
  - Anything else is illegal: all datapath outputs 0, WE3=0.
- Write to rd=0 is suppressed: WE3 stays 0, instruction retires normally.
- Outside EXEC: WE3=0 always; AD1/AD2/AD3/ImmOp/ALUsrc/ALUctrl hold their last decoded values (don't-care to the datapath).
- PC update at the end of EXEC:
  - BNE with EQ=0 sampled in EXEC: pc <= pc + ImmOp, truncated to PC_WIDTH, wraps modulo 2^PC_WIDTH.
  - Otherwise (BNE not taken, ADDI, ADD, illegal): pc <= pc + 4, wrapping.
- pc is stable during IDLE and reflects the address of the next instruction to accept.

Test Plan:
- Reset: pulse rst asynchronously → immediately pc=0, instr_ready=1, WE3=0, retire=0.
- ADDI 0x00500513 (addi x10,x0,5) accepted in IDLE → next cycle AD3=10, AD1=0, ALUsrc=1, ALUctrl=0, ImmOp=5, WE3=1 for exactly 1 cycle; following cycle retire=1; pc=4; datapath a0=5.
- BNE 0xFE659CE3 (bne x11,x6,-8) at pc=8:
  - with EQ=0 in EXEC → pc=0x0, WE3 never 1, ALUctrl=1.
  - repeat with EQ=1 → pc=0xC.
- ADD x0,x1,x2 (0x00208033) → WE3 stays 0, retire=1, pc+=4. Illegal 0xFFFFFFFF → retire=1 and illegal=1 in the same cycle, WE3=0, pc+=4.
- Back-to-back: instr_valid held high with 3 instructions → accepted exactly one per 3 cycles; instr_ready low in EXEC/RETIRE.
- Reset asserted during EXEC of ADDI x10 → no register write, pc=0, state IDLE on release.
